// File: rtl/pwm_timer_pkg.sv
// pwm_timer_pkg: register map offsets and control bit positions shared by the timer bank
package pwm_timer_pkg;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_COMPARE = 2'd2;
  localparam logic [1:0] REG_COUNT = 2'd3;
  localparam logic [1:0] REG_PRESCALE = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_START = 2'd2;
  localparam int CTRL_EN = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IE = 2;
  localparam int CTRL_INVERT = 3;
  localparam int CTRL_W = 4;
endpackage

// File: rtl/pwm_timer_channel.sv
// pwm_timer_channel: one counter/compare PWM channel holding CTRL, PERIOD, COMPARE and COUNT
module pwm_timer_channel
  import pwm_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        we_ctrl,
  input  logic        we_period,
  input  logic        we_compare,
  input  logic        we_count,
  input  logic        start,
  input  logic [31:0] wdata,
  input  logic [1:0]  rsel,
  output logic        pwm,
  output logic        wrap,
  output logic        ie,
  output logic [31:0] rdata
);
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0] period_q, period_d, compare_q, compare_d, count_q, count_d;
  logic pwm_q, pwm_d, step;
  always_comb begin
    step = tick & ctrl_q[CTRL_EN] & ~we_count & ~start;
    wrap = step & (count_q >= period_q);
    ctrl_d = we_ctrl ? wdata[CTRL_W-1:0] : ctrl_q;
    ctrl_d[CTRL_EN] = start | (we_ctrl ? wdata[CTRL_EN] : ctrl_q[CTRL_EN] & ~(wrap & ctrl_q[CTRL_ONESHOT]));
    period_d = we_period ? wdata[CNT_W-1:0] : period_q;
    compare_d = we_compare ? wdata[CNT_W-1:0] : compare_q;
    count_d = start ? '0 : we_count ? wdata[CNT_W-1:0] : wrap ? '0 : step ? count_q + CNT_W'(1) : count_q;
    pwm_d = (ctrl_q[CTRL_EN] & (count_q < compare_q)) ^ ctrl_q[CTRL_INVERT];
    rdata = rsel == REG_CTRL ? 32'(ctrl_q) : rsel == REG_PERIOD ? 32'(period_q) :
            rsel == REG_COMPARE ? 32'(compare_q) : 32'(count_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      period_q <= '0;
      compare_q <= '0;
      count_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      period_q <= period_d;
      compare_q <= compare_d;
      count_q <= count_d;
      pwm_q <= pwm_d;
    end
  end
  assign pwm = pwm_q;
  assign ie = ctrl_q[CTRL_IE];
endmodule

// File: rtl/pwm_timer_bank.sv
// pwm_timer_bank: Avalon-MM multi-channel PWM/timer with shared prescaler, W1C status and level irq
module pwm_timer_bank
  import pwm_timer_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W = 32,
  parameter int PRESCALE_W = 16,
  localparam int ADDR_W = $clog2(NUM_CH) + 3
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] pwm_export,
  output logic              irq
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic [NUM_CH-1:0] status_q, status_d, wrap, ie, start;
  logic [31:0] ch_rdata [NUM_CH];
  logic [31:0] rdata_q, rdata_d;
  logic irq_q, irq_d, tick, glob, gw;
  logic [1:0] reg_sel;
  logic [CH_W-1:0] ch_sel;
  always_comb begin
    glob = avs_address[ADDR_W-1];
    reg_sel = avs_address[1:0];
    ch_sel = CH_W'(avs_address >> 2) & CH_W'(NUM_CH - 1);
    gw = avs_write & glob;
    tick = pcnt_q == prescale_q;
    start = (gw && reg_sel == REG_START) ? avs_writedata[NUM_CH-1:0] : '0;
    prescale_d = (gw && reg_sel == REG_PRESCALE) ? avs_writedata[PRESCALE_W-1:0] : prescale_q;
    pcnt_d = ((gw && reg_sel == REG_PRESCALE) || tick) ? '0 : pcnt_q + PRESCALE_W'(1);
    status_d = (status_q & ~((gw && reg_sel == REG_STATUS) ? avs_writedata[NUM_CH-1:0] : '0)) | wrap;
    irq_d = |(status_q & ie);
    rdata_d = !avs_read ? '0 : !glob ? ch_rdata[ch_sel] : reg_sel == REG_PRESCALE ? 32'(prescale_q) :
              reg_sel == REG_STATUS ? 32'(status_q) : '0;
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      prescale_q <= '0;
      pcnt_q <= '0;
      status_q <= '0;
      irq_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      prescale_q <= prescale_d;
      pcnt_q <= pcnt_d;
      status_q <= status_d;
      irq_q <= irq_d;
      rdata_q <= rdata_d;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we;
    assign we = avs_write & ~glob & (ch_sel == CH_W'(i));
    pwm_timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk(clk_clk),
      .rst(reset_reset),
      .tick(tick),
      .we_ctrl(we && reg_sel == REG_CTRL),
      .we_period(we && reg_sel == REG_PERIOD),
      .we_compare(we && reg_sel == REG_COMPARE),
      .we_count(we && reg_sel == REG_COUNT),
      .start(start[i]),
      .wdata(avs_writedata),
      .rsel(reg_sel),
      .pwm(pwm_export[i]),
      .wrap(wrap[i]),
      .ie(ie[i]),
      .rdata(ch_rdata[i])
    );
  end
  assign avs_readdata = rdata_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_pwm_timer_bank.sv
// tb_pwm_timer_bank: randomized and directed scoreboard bench against a behavioural register-map model
module tb_pwm_timer_bank;
  localparam int NCH = 4;
  localparam int AW = 5;
  localparam int unsigned CMASK = 32'hFFF;
  localparam int unsigned PMASK = 32'h3F;
  logic clk = 0;
  logic reset_reset = 0;
  logic [AW-1:0] avs_address = '0;
  logic avs_write = 0;
  logic [31:0] avs_writedata = '0;
  logic avs_read = 0;
  logic [31:0] avs_readdata;
  logic [NCH-1:0] pwm_export;
  logic irq;
  int checks = 0;
  int errs = 0;
  pwm_timer_bank #(.NUM_CH(NCH), .CNT_W(12), .PRESCALE_W(6)) dut (
    .clk_clk(clk),
    .reset_reset(reset_reset),
    .avs_address(avs_address),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_read(avs_read),
    .avs_readdata(avs_readdata),
    .pwm_export(pwm_export),
    .irq(irq)
  );
  always #5 clk = ~clk;
  bit m_en[NCH], m_os[NCH], m_ie[NCH], m_inv[NCH];
  int unsigned m_per[NCH], m_cmp[NCH], m_cnt[NCH];
  int unsigned m_presc = 0, m_pcnt = 0;
  logic [NCH-1:0] m_st = '0, pwm_m = '0;
  bit irq_m = 0, rv = 0;
  logic [31:0] rq[$];
  logic [31:0] mon_exp;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic logic [31:0] rd_val(input logic [AW-1:0] a);
    int c;
    c = int'(a[3:2]);
    if (a[4]) return a[1:0] == 0 ? m_presc : a[1:0] == 1 ? 32'(m_st) : 0;
    case (a[1:0])
      2'd0: return {28'b0, m_inv[c], m_ie[c], m_os[c], m_en[c]};
      2'd1: return m_per[c];
      2'd2: return m_cmp[c];
      default: return m_cnt[c];
    endcase
  endfunction
  task automatic model_step();
    bit tick, g, cw, sw;
    int c, r;
    logic [NCH-1:0] wr;
    logic [31:0] d;
    if (reset_reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_en[i] = 0; m_os[i] = 0; m_ie[i] = 0; m_inv[i] = 0;
        m_per[i] = 0; m_cmp[i] = 0; m_cnt[i] = 0;
      end
      m_presc = 0; m_pcnt = 0; m_st = '0; pwm_m = '0; irq_m = 0; rv = 0;
      return;
    end
    for (int i = 0; i < NCH; i++) pwm_m[i] = (m_en[i] && m_cnt[i] < m_cmp[i]) ^ m_inv[i];
    irq_m = 0;
    for (int i = 0; i < NCH; i++) if (m_st[i] && m_ie[i]) irq_m = 1;
    rv = avs_read;
    if (avs_read) rq.push_back(rd_val(avs_address));
    g = avs_address[4];
    c = int'(avs_address[3:2]);
    r = int'(avs_address[1:0]);
    d = avs_writedata;
    tick = m_pcnt == m_presc;
    wr = '0;
    for (int i = 0; i < NCH; i++) begin
      cw = avs_write && !g && c == i && r == 3;
      sw = avs_write && g && r == 2 && d[i];
      if (tick && m_en[i] && !cw && !sw) begin
        if (m_cnt[i] >= m_per[i]) begin
          m_cnt[i] = 0;
          wr[i] = 1;
          if (m_os[i]) m_en[i] = 0;
        end else m_cnt[i] = (m_cnt[i] + 1) & CMASK;
      end
    end
    m_pcnt = tick ? 0 : m_pcnt + 1;
    if (avs_write && g) begin
      if (r == 0) begin m_presc = d & PMASK; m_pcnt = 0; end
      if (r == 1) m_st = m_st & ~d[NCH-1:0];
      if (r == 2) for (int i = 0; i < NCH; i++) if (d[i]) begin m_en[i] = 1; m_cnt[i] = 0; end
    end else if (avs_write) begin
      if (r == 0) begin m_en[c] = d[0]; m_os[c] = d[1]; m_ie[c] = d[2]; m_inv[c] = d[3]; end
      if (r == 1) m_per[c] = d & CMASK;
      if (r == 2) m_cmp[c] = d & CMASK;
      if (r == 3) m_cnt[c] = d & CMASK;
    end
    m_st = m_st | wr;
  endtask
  always @(negedge clk) begin
    if (rv) begin
      mon_exp = rq.pop_front();
      chk("rdata", avs_readdata, mon_exp);
    end else chk("rdata_idle", avs_readdata, 0);
    chk("pwm", 32'(pwm_export), 32'(pwm_m));
    chk("irq", 32'(irq), 32'(irq_m));
  end
  task automatic cyc(input bit w, input bit r, input logic [AW-1:0] a, input logic [31:0] d, input bit rs);
    avs_write = w; avs_read = r; avs_address = a; avs_writedata = d; reset_reset = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    cyc(1, 0, a, d, 0);
  endtask
  task automatic rd(input logic [AW-1:0] a);
    cyc(0, 1, a, 0, 0);
  endtask
  task automatic idle();
    cyc(0, 0, '0, '0, 0);
  endtask
  function automatic logic [AW-1:0] ca(input int c, input int r);
    return {1'b0, 2'(c), 2'(r)};
  endfunction
  function automatic logic [AW-1:0] ga(input int r);
    return {3'b100, 2'(r)};
  endfunction
  initial begin
    int hi, diff, op;
    bit found;
    logic [AW-1:0] ra;
    logic [31:0] rdat;
    cyc(0, 0, '0, '0, 1);
    cyc(0, 0, '0, '0, 1);
    chk("rst_pwm", 32'(pwm_export), 0);
    chk("rst_irq", 32'(irq), 0);
    for (int a = 0; a < 32; a++) rd(AW'(a));
    wr(ga(0), 0);
    wr(ca(0, 1), 9);
    wr(ca(0, 2), 3);
    wr(ca(0, 0), 1);
    idle(); idle();
    hi = 0;
    for (int k = 0; k < 30; k++) begin idle(); hi += int'(pwm_export[0]); end
    chk("duty_3_of_10", hi, 9);
    rd(ga(1));
    wr(ca(0, 0), 0);
    wr(ga(1), 32'hF);
    wr(ga(0), 4);
    wr(ca(1, 1), 1);
    wr(ca(1, 0), 7);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_pcnt == m_presc && m_en[1] && m_cnt[1] >= m_per[1]) begin
        wr(ga(1), 2);
        found = 1;
      end else idle();
    end
    chk("wrap_seen", 32'(found), 1);
    rd(ga(1));
    chk("status_set_beats_w1c", 32'(avs_readdata[1]), 1);
    chk("irq_rise", 32'(irq), 1);
    rd(ca(1, 0));
    chk("oneshot_en_clr", avs_readdata, 6);
    wr(ga(1), 2);
    idle();
    chk("irq_drop", 32'(irq), 0);
    wr(ga(0), 0);
    wr(ca(0, 0), 0); wr(ca(0, 1), 7); wr(ca(0, 2), 4);
    wr(ca(2, 0), 0); wr(ca(2, 1), 7); wr(ca(2, 2), 4);
    wr(ga(2), 5);
    idle();
    hi = 0; diff = 0;
    for (int k = 0; k < 24; k++) begin
      idle();
      diff += int'(pwm_export[0] != pwm_export[2]);
      hi += int'(pwm_export[0]);
    end
    chk("start_sync", diff, 0);
    chk("start_duty", hi, 12);
    wr(ca(0, 0), 0);
    wr(ca(2, 0), 8);
    wr(ga(2), 5);
    idle();
    diff = 0;
    for (int k = 0; k < 24; k++) begin idle(); diff += int'(pwm_export[0] == pwm_export[2]); end
    chk("invert_compl", diff, 0);
    wr(ca(0, 0), 0); wr(ca(2, 0), 0);
    wr(ga(0), 1);
    wr(ca(3, 1), 100); wr(ca(3, 2), 50); wr(ca(3, 3), 50); wr(ca(3, 0), 1);
    wr(ga(1), 32'hF);
    for (int k = 0; k < 4; k++) idle();
    wr(ca(3, 1), 20);
    idle(); idle(); idle();
    rd(ga(1));
    chk("shrink_wrap", 32'(avs_readdata[3]), 1);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (m_pcnt == m_presc) begin wr(ca(3, 3), 5); found = 1; end else idle();
    end
    rd(ca(3, 3));
    chk("count_load_in_tick", avs_readdata, 5);
    wr(ca(3, 0), 5);
    idle(); idle();
    chk("irq_pre_reset", 32'(irq), 1);
    cyc(1, 1, ga(0), 3, 1);
    chk("reset_pwm", 32'(pwm_export), 0);
    chk("reset_irq", 32'(irq), 0);
    chk("reset_rdata", avs_readdata, 0);
    for (int a = 0; a < 32; a++) rd(AW'(a));
    for (int k = 0; k < 3000; k++) begin
      op = int'($urandom_range(0, 99));
      ra = AW'($urandom);
      rdat = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 20);
      if (op < 1) cyc(0, $urandom_range(0, 1) == 0, ra, rdat, 1);
      else if (op < 30) cyc(1, $urandom_range(0, 3) == 0, ra, rdat, 0);
      else if (op < 55) rd(ra);
      else idle();
    end
    idle();
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pwm_timer_bank.md
# pwm_timer_bank

Parametrised multi-channel timer/PWM peripheral that replaces the fixed 8-bit LED output port of the timer system. It presents an Avalon-MM slave (32-bit, fixed read latency 1, no wait states) to the Nios master. It drives `NUM_CH` independent PWM/timer channels from one shared prescaler onto `pwm_export`, with a combined interrupt line. It adds one-shot mode, output inversion, per-channel interrupts and synchronous multi-channel start.

## Interface
- `NUM_CH`, 8: channel count; power of two, 1..16.
- `CNT_W`, 32: channel counter/period/compare width; 1..32.
- `PRESCALE_W`, 16: prescaler width; 1..32.
- `ADDR_W`, derived: $clog2(NUM_CH)+3, not overridable.
- `clk_clk`  in  1  sole clock.
- `reset_reset`  in  1  reset; one clock, reset is synchronous and active-high.
- `avs_address`  in  ADDR_W  word address: {global, ch, reg[1:0]}.
- `avs_write`  in  1  write strobe.
- `avs_writedata`  in  32  write data.
- `avs_read`  in  1  read strobe.
- `avs_readdata`  out  32  read data, valid the cycle after `avs_read`.
- `pwm_export`  out  NUM_CH  PWM outputs, bit i = channel i.
- `irq`  out  1  level interrupt.

## Operation
- Channel registers, global bit 0, reg offsets:
  - 0 CTRL: [0] EN, [1] ONESHOT, [2] IE, [3] INVERT.
  - 1 PERIOD.
  - 2 COMPARE.
  - 3 COUNT; a write loads the counter.
- Global registers, global bit 1, reg offsets:
  - 0 PRESCALE.
  - 1 STATUS: NUM_CH wrap flags, write-1-to-clear.
  - 2 START: write-only mask; each set bit sets EN and clears COUNT of that channel in the same cycle. Reads return 0.
  - 3 reserved, reads 0.
- Field widths:
  - Writes truncate to field width.
  - Reads zero-extend.
  - Channel index ≥ NUM_CH is impossible by construction.
- Prescaler:
  - `pcnt` counts 0..PRESCALE, then wraps to 0.
  - `tick` is asserted in the cycle where `pcnt`==PRESCALE. PRESCALE=0 gives a tick every cycle.
  - A write to PRESCALE clears `pcnt`.
- Channel on `tick` with EN=1:
  - If COUNT ≥ PERIOD: COUNT←0, wrap event. Using ≥ means shrinking PERIOD mid-cycle wraps on the next tick.
  - Otherwise COUNT←COUNT+1, no saturation concern, since COUNT ≤ PERIOD after the first wrap.
- Wrap event:
  - Sets STATUS[i].
  - If ONESHOT=1, EN←0 in the same cycle; COUNT stays 0.
- EN=0: counter holds its value.
- PWM level per channel:
  - lvl = EN & (COUNT < COMPARE).
  - `pwm_export[i]` = lvl XOR INVERT, registered.
  - COMPARE=0 gives constant INVERT. COMPARE > PERIOD gives constant !INVERT while enabled.
- `irq` = |(STATUS & IE), registered.
- Priority rules:
  - Bus write to COUNT, CTRL, or START beats tick update in the same cycle.
  - STATUS set beats W1C clear in the same cycle.
- Read side: `avs_readdata` is 0 in cycles not following a read.

## Timing
- Reset values: all registers 0, `pcnt` 0, `pwm_export` 0, `irq` 0, `avs_readdata` 0. Reset mid-period aborts counting immediately.
- Register write takes effect on the clock edge of `avs_write`. Its effect on `pwm_export`/`irq` is visible one cycle later.
- Read latency is exactly 1 cycle. Simultaneous `avs_read` and `avs_write` are legal: read returns the pre-write value.
- PWM period = (PERIOD+1)·(PRESCALE+1) cycles. High time = min(COMPARE, PERIOD+1)·(PRESCALE+1) cycles (INVERT=0).
- Channels started by one START write stay phase-aligned for identical PERIOD and PRESCALE.

## Structure
- Package `pwm_timer_pkg`:
  - Register offsets: REG_CTRL, REG_PERIOD, REG_COMPARE, REG_COUNT, REG_PRESCALE, REG_STATUS, REG_START.
  - CTRL bit indices.
- Sub-module `pwm_timer_channel`, instantiated NUM_CH times via generate:
  - Holds CTRL, PERIOD, COMPARE, COUNT.
  - Inputs: tick, load strobes, start.
  - Outputs: pwm bit, wrap pulse, register readback.
- Top level owns: prescaler, STATUS, irq, address decode, read mux.

## Test plan
- Reset then read all registers → all 0; `pwm_export`=0, `irq`=0.
- PRESCALE=0; ch0 PERIOD=9, COMPARE=3, CTRL=EN → `pwm_export[0]` high 3 of every 10 cycles; STATUS[0] sets every 10 cycles.
- PRESCALE=4; ch1 PERIOD=1, ONESHOT|IE|EN → wrap after 10 cycles; EN clears; `irq` rises 1 cycle after the wrap. W1C of STATUS=0x2 drops `irq`. W1C in the wrap cycle leaves STATUS set.
- START=0x05 with ch0 and ch2 at PERIOD=7, COMPARE=4 → outputs identical every cycle. ch2 INVERT=1 → exact complement.
- ch3 running with PERIOD=100, COUNT≈50; write PERIOD=20 → wrap on the next tick. Write COUNT=5 in a tick cycle → COUNT reads 5, not 6.
- Assert `reset_reset` mid-period with `irq` high → next cycle all outputs 0 and registers cleared.
